// File: rtl/rvc_fetch_aligner.sv
// Streaming fetch aligner: buffers fetch halfwords, extracts mixed 16/32-bit
// instructions and expands RV32C encodings for decode, one per cycle.
module rvc_fetch_aligner #(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned BUF_HW   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc,
  output logic               out_compressed,
  output logic               out_illegal
);

  localparam int unsigned NHW = FETCH_W / 16;
  localparam int unsigned IW  = $clog2(BUF_HW);
  localparam int unsigned OW  = $clog2(BUF_HW + 1);
  localparam int unsigned SW  = $clog2(NHW);

  // Returns {illegal, expanded instruction}.
  function automatic logic [32:0] rvc_expand(input logic [15:0] c);
    logic [31:0] inst;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p, rs2p;
    logic [11:0] imm6, i16;
    logic [20:1] jimm;
    logic [12:1] bimm;
    logic [9:0]  uimm;
    logic [6:0]  off7;
    logic [7:0]  lwsp_off, swsp_off;
    logic [2:0]  f3a;
    inst     = 32'h0000_0013;
    ill      = 1'b0;
    rd       = c[11:7];
    rs2      = c[6:2];
    rdp      = {2'b01, c[4:2]};
    rs1p     = {2'b01, c[9:7]};
    rs2p     = {2'b01, c[4:2]};
    imm6     = {{7{c[12]}}, c[6:2]};
    i16      = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
    jimm     = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    bimm     = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};
    uimm     = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    off7     = {c[5], c[12:10], c[6], 2'b00};
    lwsp_off = {c[3:2], c[12], c[6:4], 2'b00};
    swsp_off = {c[8:7], c[12:9], 2'b00};
    f3a      = 3'b000;
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        inst = {2'b00, uimm, 5'd2, 3'b000, rdp, 7'h13};
        ill  = (uimm == '0);
      end
      5'b00_010: inst = {5'b0, off7, rs1p, 3'b010, rdp, 7'h03};
      5'b00_110: inst = {5'b0, off7[6:5], rs2p, rs1p, 3'b010, off7[4:0], 7'h23};
      5'b01_000: inst = {imm6, rd, 3'b000, rd, 7'h13};
      5'b01_001: inst = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'h6F};
      5'b01_010: inst = {imm6, 5'd0, 3'b000, rd, 7'h13};
      5'b01_011: begin
        ill = ({c[12], c[6:2]} == 6'b0);
        if (rd == 5'd2) inst = {i16, 5'd2, 3'b000, 5'd2, 7'h13};
        else            inst = {{15{c[12]}}, c[6:2], rd, 7'h37};
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin
            inst = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
            ill  = c[12];
          end
          2'b01: begin
            inst = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
            ill  = c[12];
          end
          2'b10: inst = {imm6, rs1p, 3'b111, rs1p, 7'h13};
          default: begin
            case (c[6:5])
              2'b00:   f3a = 3'b000;
              2'b01:   f3a = 3'b100;
              2'b10:   f3a = 3'b110;
              default: f3a = 3'b111;
            endcase
            inst = {(c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000,
                    rs2p, rs1p, f3a, rs1p, 7'h33};
            ill  = c[12];
          end
        endcase
      end
      5'b01_101: inst = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'h6F};
      5'b01_110: inst = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000, bimm[4:1], bimm[11], 7'h63};
      5'b01_111: inst = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b001, bimm[4:1], bimm[11], 7'h63};
      5'b10_000: begin
        inst = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'h13};
        ill  = c[12];
      end
      5'b10_010: begin
        inst = {4'b0, lwsp_off, 5'd2, 3'b010, rd, 7'h03};
        ill  = (rd == 5'd0);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            inst = {12'b0, rd, 3'b000, 5'd0, 7'h67};
            ill  = (rd == 5'd0);
          end else begin
            inst = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
          end
        end else begin
          if (rs2 == 5'd0) begin
            if (rd == 5'd0) inst = 32'h0010_0073;
            else            inst = {12'b0, rd, 3'b000, 5'd1, 7'h67};
          end else begin
            inst = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
          end
        end
      end
      5'b10_110: inst = {4'b0, swsp_off[7:5], rs2, 5'd2, 3'b010, swsp_off[4:0], 7'h23};
      default:   ill = 1'b1;
    endcase
    if (ill) inst = {16'h0000, c};
    return {ill, inst};
  endfunction

  logic [15:0]   buf_q [BUF_HW];
  logic [15:0]   buf_d [BUF_HW];
  logic [15:0]   word_hw [NHW];
  logic [OW-1:0] occ_q, occ_d;
  logic [SW-1:0] skip_q;
  logic [31:0]   pc_head_q;
  logic          is32, have, load, push;
  logic [32:0]   exp_res;
  int unsigned   pop_n, keep_n, push_n;
  logic          flush_pc_unused;

  // Redirect targets are halfword aligned, so bit 0 carries no information.
  assign flush_pc_unused = flush_pc[0];

  assign fetch_ready = (BUF_HW - 32'(occ_q)) >= NHW;

  always_comb begin
    for (int unsigned i = 0; i < NHW; i++) word_hw[i] = fetch_data[16*i +: 16];
  end

  always_comb begin
    is32    = (buf_q[0][1:0] == 2'b11);
    have    = is32 ? (occ_q >= OW'(2)) : (occ_q != '0);
    load    = have && (!out_valid || out_ready) && !flush;
    push    = fetch_valid && fetch_ready && !flush;
    pop_n   = load ? (is32 ? 32'd2 : 32'd1) : 32'd0;
    keep_n  = 32'(occ_q) - pop_n;
    push_n  = push ? (NHW - 32'(skip_q)) : 32'd0;
    exp_res = rvc_expand(buf_q[0]);
    // Shift out consumed halfwords, then append the surviving new ones above them.
    for (int unsigned i = 0; i < BUF_HW; i++) begin
      buf_d[i] = '0;
      if (i < keep_n)
        buf_d[i] = buf_q[IW'(i + pop_n)];
      else if ((i - keep_n) < push_n)
        buf_d[i] = word_hw[SW'(i - keep_n + 32'(skip_q))];
    end
    occ_d = OW'(keep_n + push_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q          <= '{default: '0};
      occ_q          <= '0;
      skip_q         <= '0;
      pc_head_q      <= RESET_PC;
      out_valid      <= 1'b0;
      out_inst       <= 32'h0000_0013;
      out_pc         <= RESET_PC;
      out_compressed <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      occ_q     <= '0;
      skip_q    <= flush_pc[SW:1];
      pc_head_q <= {flush_pc[31:1], 1'b0};
      out_valid <= 1'b0;
    end else begin
      buf_q <= buf_d;
      occ_q <= occ_d;
      if (push) skip_q <= '0;
      if (load) begin
        out_valid      <= 1'b1;
        out_inst       <= is32 ? {buf_q[1], buf_q[0]} : exp_res[31:0];
        out_pc         <= pc_head_q;
        out_compressed <= !is32;
        out_illegal    <= !is32 && exp_res[32];
        pc_head_q      <= pc_head_q + (is32 ? 32'd4 : 32'd2);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench for rvc_fetch_aligner: hand-computed expected instruction
// stream, checked at each output handshake.
module tb_rvc_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        out_illegal;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rvc_fetch_aligner #(
    .FETCH_W (32),
    .BUF_HW  (6),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_data    (fetch_data),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_compressed(out_compressed),
    .out_illegal   (out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] inst, input logic [31:0] pc,
                            input logic comp, input logic ill);
    exp_q.push_back('{inst: inst, pc: pc, comp: comp, ill: ill});
  endtask

  task automatic push_word(input logic [31:0] w);
    int unsigned n = 0;
    fetch_valid = 1'b1;
    fetch_data  = w;
    while (!fetch_ready && n < 20) begin
      tick();
      n++;
    end
    if (!fetch_ready) chk("push_timeout", 32'(fetch_ready), 32'd1);
    else tick();
    fetch_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Handshake completes at the next rising edge; check it mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("inst", out_inst, e.inst);
        chk("pc", out_pc, e.pc);
        chk("comp", 32'(out_compressed), 32'(e.comp));
        chk("ill", 32'(out_illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    int unsigned n;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'h0000_0013);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_comp", 32'(out_compressed), 32'd0);
    chk("rst_ill", 32'(out_illegal), 32'd0);
    chk("rst_fready", 32'(fetch_ready), 32'd1);
    rst = 1'b0;

    // Two compressed instructions in one word
    expect_out(32'h0010_8093, 32'h0, 1'b1, 1'b0);
    expect_out(32'h0007_A703, 32'h2, 1'b1, 1'b0);
    push_word(32'h4398_0085);
    wait_drain("drain_basic");

    // 32-bit instruction straddling two fetch words
    do_reset();
    expect_out(32'h0000_0013, 32'h0, 1'b1, 1'b0);
    expect_out(32'h0050_0513, 32'h2, 1'b0, 1'b0);
    expect_out(32'h0000_0013, 32'h6, 1'b1, 1'b0);
    push_word(32'h0513_0001);
    tick();
    tick();
    tick();
    chk("straddle_wait_q", 32'(exp_q.size()), 32'd2);
    chk("straddle_wait_valid", 32'(out_valid), 32'd0);
    push_word(32'h0001_0050);
    wait_drain("drain_straddle");

    // Backpressure: outputs hold, buffer fills, fetch_ready drops
    do_reset();
    out_ready = 1'b0;
    push_word(32'h4398_0085);
    push_word(32'h0001_0001);
    push_word(32'h0085_0001);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_inst", out_inst, 32'h0010_8093);
      chk("bp_pc", out_pc, 32'h0);
      chk("bp_fready", 32'(fetch_ready), 32'd0);
      tick();
    end
    expect_out(32'h0010_8093, 32'h0, 1'b1, 1'b0);
    expect_out(32'h0007_A703, 32'h2, 1'b1, 1'b0);
    expect_out(32'h0000_0013, 32'h4, 1'b1, 1'b0);
    expect_out(32'h0000_0013, 32'h6, 1'b1, 1'b0);
    expect_out(32'h0000_0013, 32'h8, 1'b1, 1'b0);
    expect_out(32'h0010_8093, 32'hA, 1'b1, 1'b0);
    out_ready = 1'b1;
    wait_drain("drain_bp");

    // Flush to an odd halfword; fetch word in the flush cycle is discarded
    do_reset();
    flush       = 1'b1;
    flush_pc    = 32'h0000_0102;
    fetch_valid = 1'b1;
    fetch_data  = 32'h0001_0001;
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    expect_out(32'h0010_8093, 32'h102, 1'b1, 1'b0);
    expect_out(32'h0000_0013, 32'h104, 1'b1, 1'b0);
    expect_out(32'h0000_0013, 32'h106, 1'b1, 1'b0);
    push_word(32'h0085_0001);
    push_word(32'h0001_0001);
    wait_drain("drain_flush");

    // Illegal encodings: all-zero halfword and LWSP with rd=0
    do_reset();
    expect_out(32'h0000_0000, 32'h0, 1'b1, 1'b1);
    expect_out(32'h0000_4002, 32'h2, 1'b1, 1'b1);
    push_word(32'h4002_0000);
    wait_drain("drain_illegal");

    // Asynchronous reset between edges while an output is held
    do_reset();
    out_ready = 1'b0;
    flush     = 1'b1;
    flush_pc  = 32'h0000_0040;
    tick();
    flush = 1'b0;
    push_word(32'h0085_0085);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_pc", out_pc, 32'h40);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_pc", out_pc, 32'h0);
    chk("ar_inst", out_inst, 32'h0000_0013);
    chk("ar_fready", 32'(fetch_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("ar_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
